data_ram_resp: RTL

DATA_RAM_RESP -- requirements
Module: data_ram_resp

---
 rtl/data_ram_resp_pkg.sv | 17 +
 rtl/data_ram_resp_ram_array.sv | 18 +
 rtl/data_ram_resp.sv | 126 ++++++++++++
 3 files changed

// File: rtl/data_ram_resp_pkg.sv
// Shared types and limits for the data RAM responder: FSM encoding, latency bounds, latched request.
package data_ram_resp_pkg;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/data_ram_resp_ram_array.sv
// Single-port 32-bit storage: synchronous write, registered read, no reset.
module ram_array #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/data_ram_resp.sv
// Multi-cycle data RAM responder: stalls the core for LATENCY+1 cycles per access, then one DONE cycle.
// Define RAM_ERR_CHK_EN to flag misaligned / out-of-range addresses on ram_err.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_rst,
  input  logic        ram_cs,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        ram_stall,
  output logic        ram_err
);
  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("data_ram_resp: LATENCY out of range");
  end

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  req_t                    lat;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic                    req, addr_err, lat_en;
  logic                    stall_c, wr_en, rd_en, err_nxt;
  logic                    rd_valid;
  logic [31:0]             rd_q;

  assign req = ram_cs & (mem_ren | mem_wen);

`ifdef RAM_ERR_CHK_EN
  logic err_q;
  assign addr_err = (|mem_addr[1:0]) | (|mem_addr[31:ADDR_WIDTH+2]);
  assign ram_err  = err_q;
`else
  logic unused_ok;
  assign addr_err  = 1'b0;
  assign ram_err   = 1'b0;
  assign unused_ok = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0], err_nxt};
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    err_nxt   = 1'b0;
    lat_en    = 1'b0;
    if (ram_rst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          stall_c = 1'b1;
          lat_en  = 1'b1;
          if (addr_err) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
        BUSY: begin
          stall_c = 1'b1;
          if (cnt == '0) begin
            state_nxt = DONE;
            wr_en     = lat.wr;
            rd_en     = ~lat.wr;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Gate with rst so stall reads 0 while reset is held, even with a request present.
  assign ram_stall = stall_c & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat      <= '0;
      lat_idx  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (lat_en) begin
        lat.wr    <= mem_wen;
        lat.wdata <= mem_dout;
        lat_idx   <= mem_addr[ADDR_WIDTH+1:2];
      end
      if (rd_en) rd_valid <= 1'b1;
    end
  end

`ifdef RAM_ERR_CHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_nxt;
  end
`endif

  // The array has no reset; mem_din reads 0 until a read completes after reset.
  assign mem_din = rd_valid ? rd_q : 32'h0;

  ram_array #(.AW(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (lat_idx),
    .wdata (lat.wdata),
    .rdata (rd_q)
  );
endmodule
